// File: rtl/cell_access_arbiter.sv
// ---------------------------------------------------------------------------
// cell_access_arbiter
//
// Shares one single-port cell position RAM (2-cycle read latency, word 0 holds
// the particle count) between two force-evaluation readers and one
// motion-update writer. After reset it fetches word 0 into a shadow
// particle_count register. It then grants at most one RAM access per cycle.
// The writer has priority. The two readers alternate round-robin. Each read is
// bounds-checked against the shadow count.
//
// Ports
//   clk, rst_n            clock (rising edge) and async active-low reset
//   rd0_req/rd0_addr      reader 0 level request + particle address
//   rd0_gnt               reader 0 accepted this cycle (combinational)
//   rd0_valid             rd_data belongs to reader 0 (3 cycles after grant)
//   rd1_*                 same set for reader 1
//   rd_data               shared read data, 0 when no valid or out of bounds
//   rd_oob                read was out of bounds (addr 0 or > particle_count)
//   wr_req/wr_addr/wr_data  writer level request, address, data
//   wr_gnt                write accepted this cycle (combinational)
//   mem_address/mem_data/mem_rden/mem_wren  registered RAM port drive
//   mem_q                 RAM read data
//   particle_count        shadow of RAM word 0 low bits
//   init_done             particle_count valid, arbitration enabled
// ---------------------------------------------------------------------------
module cell_access_arbiter #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd0_req,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  output logic                  rd0_gnt,
  output logic                  rd0_valid,
  input  logic                  rd1_req,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd1_gnt,
  output logic                  rd1_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_oob,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  init_done
);

  typedef enum logic [1:0] {
    INIT_RD    = 2'd0,
    INIT_WAIT  = 2'd1,
    INIT_LATCH = 2'd2,
    SERVE      = 2'd3
  } state_t;

  // One extra bit so depths up to 2**ADDR_WIDTH compare correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(PARTICLE_NUM);

  state_t                state_r;
  state_t                state_s;
  logic                  wait_cnt_r;
  logic                  rr_r;          // 0: reader 0 wins a tie, 1: reader 1 wins
  logic [2:0]            tag_valid_r;   // bit 2 is the oldest stage
  logic [2:0]            tag_id_r;
  logic [2:0]            tag_oob_r;

  logic                  serve_s;
  logic                  rd_slot_s;
  logic                  rd_gnt_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic                  rd_oob_s;
  logic                  wr_keep_s;

  // FSM state register and init wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= INIT_RD;
      wait_cnt_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= (state_r == INIT_WAIT) ? ~wait_cnt_r : 1'b0;
    end
  end

  // FSM next state: one read of word 0, two wait cycles, latch, then serve.
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT_RD:    state_s = INIT_WAIT;
      INIT_WAIT: begin
        if (wait_cnt_r) begin
          state_s = INIT_LATCH;
        end else begin
          state_s = INIT_WAIT;
        end
      end
      INIT_LATCH: state_s = SERVE;
      SERVE:      state_s = SERVE;
      default:    state_s = INIT_RD;
    endcase
  end

  // Grant selection: writer first, then round-robin between the readers.
  always_comb begin
    serve_s   = (state_r == SERVE);
    wr_gnt    = serve_s & wr_req;
    rd_slot_s = serve_s & ~wr_req;
    rd0_gnt   = rd_slot_s & rd0_req & (~rd1_req | ~rr_r);
    rd1_gnt   = rd_slot_s & rd1_req & (~rd0_req |  rr_r);
    rd_gnt_s  = rd0_gnt | rd1_gnt;
    if (rd1_gnt) begin
      rd_addr_s = rd1_addr;
    end else begin
      rd_addr_s = rd0_addr;
    end
    // Word 0 is the count itself, not a particle.
    rd_oob_s  = (rd_addr_s == {ADDR_WIDTH{1'b0}}) || (rd_addr_s > particle_count);
    wr_keep_s = ({1'b0, wr_addr} < DEPTH);
  end

  // RAM port drive; address and data hold on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address <= {ADDR_WIDTH{1'b0}};
      mem_data    <= {DATA_WIDTH{1'b0}};
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
    end else if (state_r == INIT_RD) begin
      mem_address <= {ADDR_WIDTH{1'b0}};
      mem_rden    <= 1'b1;
      mem_wren    <= 1'b0;
    end else if (wr_gnt) begin
      mem_address <= wr_addr;
      mem_data    <= wr_data;
      mem_rden    <= 1'b0;
      mem_wren    <= wr_keep_s;
    end else if (rd_gnt_s) begin
      mem_address <= rd_addr_s;
      mem_rden    <= ~rd_oob_s;
      mem_wren    <= 1'b0;
    end else begin
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
    end
  end

  // Particle count shadow: loaded at init, refreshed by writes to word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      particle_count <= {ADDR_WIDTH{1'b0}};
      init_done      <= 1'b0;
    end else if (state_r == INIT_LATCH) begin
      particle_count <= mem_q[ADDR_WIDTH-1:0];
      init_done      <= 1'b1;
    end else if (wr_gnt && (wr_addr == {ADDR_WIDTH{1'b0}})) begin
      particle_count <= wr_data[ADDR_WIDTH-1:0];
    end
  end

  // Round-robin pointer moves to the reader that did not just win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r <= 1'b0;
    end else if (rd0_gnt) begin
      rr_r <= 1'b1;
    end else if (rd1_gnt) begin
      rr_r <= 1'b0;
    end
  end

  // Tag pipe aligns each read grant with mem_q three cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_r <= 3'b000;
      tag_id_r    <= 3'b000;
      tag_oob_r   <= 3'b000;
    end else begin
      tag_valid_r <= {tag_valid_r[1:0], rd_gnt_s};
      tag_id_r    <= {tag_id_r[1:0], rd1_gnt};
      tag_oob_r   <= {tag_oob_r[1:0], rd_gnt_s & rd_oob_s};
    end
  end

  // Read response decode from the oldest tag stage.
  always_comb begin
    rd0_valid = tag_valid_r[2] & ~tag_id_r[2];
    rd1_valid = tag_valid_r[2] &  tag_id_r[2];
    rd_oob    = tag_valid_r[2] &  tag_oob_r[2];
    if (tag_valid_r[2] && !tag_oob_r[2]) begin
      rd_data = mem_q;
    end else begin
      rd_data = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_cell_access_arbiter.sv
module tb_cell_access_arbiter;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd0_req, rd1_req, wr_req;
  logic [AW-1:0] rd0_addr, rd1_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd0_gnt, rd1_gnt, wr_gnt, rd0_valid, rd1_valid, rd_oob;
  logic [DW-1:0] rd_data, mem_data, mem_q;
  logic [AW-1:0] mem_address, particle_count;
  logic          mem_rden, mem_wren, init_done;

  always #5 clk = ~clk;

  cell_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt), .rd0_valid(rd0_valid),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt), .rd1_valid(rd1_valid),
    .rd_data(rd_data), .rd_oob(rd_oob),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_q(mem_q), .particle_count(particle_count), .init_done(init_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tb_cyc;

  typedef struct {
    bit            id;
    logic [DW-1:0] data;
    bit            oob;
    int            due;
  } rsp_t;
  rsp_t sb_q[$];

  bit seen_g0, seen_g1, seen_gw;

  function automatic logic [DW-1:0] init_word(input int i);
    logic [31:0] iv;
    iv = i;
    if (i == 0) return 96'd13;
    return {iv * 32'h9E3779B1, iv ^ 32'hA5A50000, iv * 32'd7 + 32'd3};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  // Cycle index since the last reset release (cycle 0 = first cycle out of reset)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  // Behavioural RAM: write on the cycle mem_wren is seen, data out two edges after rden
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] ram_s1, mem_q_r;
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (mem_wren) begin
      ram[mem_address] <= mem_data;
    end
    if (mem_rden) ram_s1 <= ram[mem_address];
    mem_q_r <= ram_s1;
  end
  assign mem_q = mem_q_r;

  // Reference model: expected grants, RAM port activity, count and read responses
  logic [DW-1:0] ref_mem [0:255];
  bit            ref_loaded = 1'b0;
  int            m_count;
  bit            m_rr;        // 1: reader 1 is favoured on a tie
  bit            e_rden, e_wren;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  always @(negedge clk) begin : model
    bit serve, gw, g0, g1, oob;
    logic [AW-1:0] ra;
    rsp_t r;
    if (!ref_loaded) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      ref_loaded = 1'b1;
    end
    if (!rst_n) begin
      m_count = 0; m_rr = 1'b0; e_rden = 1'b0; e_wren = 1'b0;
      seen_g0 = 1'b0; seen_g1 = 1'b0; seen_gw = 1'b0;
      sb_q.delete();
    end else begin
      chk("init_done", 96'(init_done), 96'(tb_cyc >= 4));
      chk("particle_count", 96'(particle_count), 96'(m_count));
      chk("mem_rden", 96'(mem_rden), 96'(e_rden));
      chk("mem_wren", 96'(mem_wren), 96'(e_wren));
      if (e_rden || e_wren) chk("mem_address", 96'(mem_address), 96'(e_addr));
      if (e_wren) chk("mem_data", mem_data, e_data);

      serve = (tb_cyc >= 4);
      gw = serve && wr_req;
      g0 = 1'b0; g1 = 1'b0;
      if (serve && !wr_req) begin
        if (rd0_req && rd1_req) begin g0 = !m_rr; g1 = m_rr; end
        else begin g0 = rd0_req; g1 = rd1_req; end
      end
      chk("wr_gnt", 96'(wr_gnt), 96'(gw));
      chk("rd0_gnt", 96'(rd0_gnt), 96'(g0));
      chk("rd1_gnt", 96'(rd1_gnt), 96'(g1));

      e_rden = 1'b0; e_wren = 1'b0;
      if (tb_cyc == 0) begin
        e_rden = 1'b1; e_addr = '0;
      end else if (tb_cyc == 3) begin
        m_count = int'(ref_mem[0][AW-1:0]);
      end else if (gw) begin
        e_addr = wr_addr; e_data = wr_data;
        if (int'(wr_addr) < PN) begin
          e_wren = 1'b1;
          ref_mem[wr_addr] = wr_data;
        end
        if (int'(wr_addr) == 0) m_count = int'(wr_data[AW-1:0]);
      end else if (g0 || g1) begin
        ra = g1 ? rd1_addr : rd0_addr;
        oob = (int'(ra) == 0) || (int'(ra) > m_count);
        e_rden = !oob; e_addr = ra;
        r.id = g1; r.oob = oob; r.due = tb_cyc + 3;
        r.data = oob ? 96'd0 : ref_mem[ra];
        sb_q.push_back(r);
        m_rr = g0;
      end
      seen_g0 = rd0_gnt; seen_g1 = rd1_gnt; seen_gw = wr_gnt;
    end
  end

  // Monitor: pops the scoreboard whenever a read response is presented
  always @(negedge clk) begin : monitor
    rsp_t r;
    if (!rst_n) begin
      chk("valid_in_reset", 96'(rd0_valid | rd1_valid), 96'd0);
    end else if (rd0_valid || rd1_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 96'(rd0_valid | rd1_valid), 96'd0);
      end else begin
        r = sb_q.pop_front();
        chk("rd_valid_id", 96'({rd1_valid, rd0_valid}), 96'({r.id, !r.id}));
        chk("rd_data", rd_data, r.data);
        chk("rd_oob", 96'(rd_oob), 96'(r.oob));
        chk("rd_latency", 96'(tb_cyc), 96'(r.due));
      end
    end else begin
      chk("rd_data_idle", rd_data, 96'd0);
      chk("rd_oob_idle", 96'(rd_oob), 96'd0);
      if (sb_q.size() > 0 && sb_q[0].due <= tb_cyc) begin
        r = sb_q.pop_front();
        chk("missing_valid", 96'(rd0_valid | rd1_valid), 96'd1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise the given requests and hold each until its grant is seen
  task automatic drive(input bit r0, input logic [AW-1:0] a0, input bit r1, input logic [AW-1:0] a1,
                       input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int t;
    t = 0;
    rd0_req = r0; rd0_addr = a0; rd1_req = r1; rd1_addr = a1;
    wr_req = w; wr_addr = wa; wr_data = wd;
    while ((rd0_req || rd1_req || wr_req) && t < 30) begin
      @(posedge clk); #1; t++;
      if (seen_g0) rd0_req = 1'b0;
      if (seen_g1) rd1_req = 1'b0;
      if (seen_gw) wr_req = 1'b0;
    end
    if (rd0_req || rd1_req || wr_req) begin
      chk("grant_timeout", 96'({rd0_req, rd1_req, wr_req}), 96'd0);
      rd0_req = 1'b0; rd1_req = 1'b0; wr_req = 1'b0;
    end
  endtask

  // Random traffic: each requester re-rolls after its grant (percent probabilities)
  task automatic run_phase(input int n, input int p0, input int p1, input int pw);
    int sel;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (!rd0_req || seen_g0) begin
        rd0_req = ($urandom_range(0, 99) < p0);
        rd0_addr = 8'($urandom_range(0, 45));
      end
      if (!rd1_req || seen_g1) begin
        rd1_req = ($urandom_range(0, 99) < p1);
        rd1_addr = 8'($urandom_range(0, 45));
      end
      if (!wr_req || seen_gw) begin
        wr_req = ($urandom_range(0, 99) < pw);
        sel = int'($urandom_range(0, 99));
        if (sel < 5)       wr_addr = 8'd0;
        else if (sel < 12) wr_addr = 8'($urandom_range(220, 255));
        else               wr_addr = 8'($urandom_range(1, 40));
        wr_data = {$urandom, $urandom, $urandom};
        wr_data[7:0] = 8'($urandom_range(5, 40));
      end
    end
    rd0_req = 1'b0; rd1_req = 1'b0; wr_req = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    rd0_req = 1'b0; rd1_req = 1'b0; wr_req = 1'b0;
    rd0_addr = '0; rd1_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Request waits through init, then lone read of word 5
    drive(1'b1, 8'd5, 1'b0, 8'd0, 1'b0, 8'd0, 96'd0);
    idle(5);
    // Both readers continuously requesting: alternate grants
    run_phase(8, 100, 100, 0);
    idle(5);
    // Write count 20 against a read, then in-bounds 18 and out-of-bounds 21
    drive(1'b1, 8'd18, 1'b0, 8'd0, 1'b1, 8'd0, 96'd20);
    drive(1'b1, 8'd21, 1'b0, 8'd0, 1'b0, 8'd0, 96'd0);
    idle(4);
    // Dropped write beyond depth, read of word 0
    drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd220, {$urandom, $urandom, $urandom});
    drive(1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 96'd0);
    idle(4);
    // Read immediately after a write to the same address
    drive(1'b0, 8'd7, 1'b0, 8'd0, 1'b1, 8'd7, {$urandom, $urandom, $urandom});
    drive(1'b1, 8'd7, 1'b0, 8'd0, 1'b0, 8'd0, 96'd0);
    idle(4);
    // Two reads in flight, then reset: no responses, init repeats
    drive(1'b1, 8'd3, 1'b1, 8'd4, 1'b0, 8'd0, 96'd0);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(10);
    // Random mixed traffic
    run_phase(600, 60, 60, 20);
    idle(8);
    chk("scoreboard_drained", 96'(sb_q.size()), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
